// File: rtl/pixie_video_pkg.sv
// Shared types and constants for the Pixie video path: count width, doubler
// state, sync output bundle and its reset value.
package pixie_video_pkg;

  localparam int              CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
    logic de;
  } tim_t;

  localparam tim_t TIM_RST = '{hsync: 1'b0, vsync: 1'b0, hblank: 1'b1,
                               vblank: 1'b1, de: 1'b0};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pixie_line_buffer.sv
// Ping-pong 1-bit line store: two banks of DEPTH pixels, one write port and
// one registered read port on the same clock.
module pixie_line_buffer #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);

  logic mem [0:2*DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/pixie_line_doubler.sv
// Pixie scan doubler: captures each input line, replays it twice at double
// pixel rate. Define PIXIE_SCANLINES_EN to dim the second replay by 50%.
module pixie_line_doubler import pixie_video_pkg::*; #(
  parameter int          MAX_PIX = 256,
  parameter logic [23:0] FG_RGB  = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB  = 24'h000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       video_in,
  input  logic       HSync_in,
  input  logic       VSync_in,
  input  logic       HBlank_in,
  input  logic       VBlank_in,
  input  logic       video_de_in,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HSync,
  output logic       VSync,
  output logic       HBlank,
  output logic       VBlank,
  output logic       video_de,
  output logic       line_err
);

  localparam int               AW        = $clog2(MAX_PIX);
  localparam logic [CNT_W-1:0] MAX_PIX_C = CNT_W'(MAX_PIX);

  // HBlank_in carries nothing beyond video_de_in
  logic unused_hblank;
  assign unused_hblank = HBlank_in;

  state_e           state;
  logic             hs_prev, wr_bank, err_done;
  logic [CNT_W-1:0] p_cnt, hw_cnt, ds_cnt, de_cnt;
  logic [CNT_W-1:0] p_l, hw_l, ds_l, dl_l;
  logic             vs_l, vb_l;
  logic [CNT_W-1:0] out_x;
  logic             half, ovr;
  tim_t             tim_d, tim_q;
  logic             pix_q;

  // The rise sample is index 0 of the new line, so counters restart through it.
  logic             rise, wr_bank_cur, err_done_cur, ovf_de, ovf_p, err_hit, wr_en;
  logic [CNT_W-1:0] pos, de_cur;

  assign rise         = pix_ce & HSync_in & ~hs_prev;
  assign pos          = rise ? '0 : p_cnt;
  assign de_cur       = rise ? '0 : de_cnt;
  assign wr_bank_cur  = rise ? ~wr_bank : wr_bank;
  assign err_done_cur = rise ? 1'b0 : err_done;
  assign ovf_de       = video_de_in & (de_cur >= MAX_PIX_C);
  assign ovf_p        = (pos == CNT_MAX - 1'b1);
  assign err_hit      = pix_ce & ~err_done_cur & (ovf_de | ovf_p);
  assign wr_en        = pix_ce & video_de_in & ~ovf_de;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev  <= 1'b0;
      wr_bank  <= 1'b0;
      err_done <= 1'b0;
      p_cnt    <= '0;
      hw_cnt   <= '0;
      ds_cnt   <= '0;
      de_cnt   <= '0;
      p_l      <= '0;
      hw_l     <= '0;
      ds_l     <= '0;
      dl_l     <= '0;
      vs_l     <= 1'b0;
      vb_l     <= 1'b0;
      line_err <= 1'b0;
    end else begin
      line_err <= err_hit;
      if (pix_ce) begin
        hs_prev  <= HSync_in;
        p_cnt    <= sat_inc(pos);
        hw_cnt   <= rise ? CNT_W'(1) : (HSync_in ? sat_inc(hw_cnt) : hw_cnt);
        de_cnt   <= video_de_in ? sat_inc(de_cur) : de_cur;
        err_done <= err_done_cur | err_hit;
        if (video_de_in && de_cur == '0) ds_cnt <= pos;
        else if (rise)                   ds_cnt <= '0;
        if (rise) begin
          p_l     <= p_cnt;
          hw_l    <= hw_cnt;
          ds_l    <= ds_cnt;
          dl_l    <= de_cnt;
          vs_l    <= VSync_in;
          vb_l    <= VBlank_in;
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  // Replay: two halves of P clk per input line; a third wrap means the input
  // line ran long, so blank until the next rise resynchronises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      out_x <= '0;
      half  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (rise) state <= SYNC;
        SYNC:    if (rise) state <= RUN;
        default: ;
      endcase
      if (rise) begin
        out_x <= '0;
        half  <= 1'b0;
        ovr   <= 1'b0;
      end else if (state == RUN) begin
        if (out_x == p_l - 1'b1) begin
          out_x <= '0;
          if (half) ovr  <= 1'b1;
          else      half <= 1'b1;
        end else begin
          out_x <= out_x + 1'b1;
        end
      end
    end
  end

  logic [CNT_W-1:0] dl_cl;
  logic [CNT_W:0]   de_end;
  logic             run, in_de;

  assign run    = (state == RUN);
  assign dl_cl  = (dl_l > MAX_PIX_C) ? MAX_PIX_C : dl_l;
  assign de_end = {1'b0, ds_l} + {1'b0, dl_cl};
  assign in_de  = run & ~ovr & (out_x >= ds_l) & ({1'b0, out_x} < de_end);

  always_comb begin
    tim_d = TIM_RST;
    if (run) begin
      tim_d.hsync  = (out_x < hw_l);
      tim_d.vsync  = vs_l;
      tim_d.vblank = vb_l;
      tim_d.de     = in_de;
      tim_d.hblank = ~in_de;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tim_q <= TIM_RST;
    else       tim_q <= tim_d;
  end

  pixie_line_buffer #(.DEPTH(MAX_PIX)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (wr_bank_cur),
    .wr_addr (de_cur[AW-1:0]),
    .wr_data (video_in),
    .rd_bank (~wr_bank),
    .rd_addr (AW'(out_x - ds_l)),
    .rd_data (pix_q)
  );

`ifdef PIXIE_SCANLINES_EN
  logic half_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) half_q <= 1'b0;
    else       half_q <= half;
  end
`endif

  logic [23:0] col;
  always_comb begin
    col = '0;
    if (tim_q.de) col = pix_q ? FG_RGB : BG_RGB;
`ifdef PIXIE_SCANLINES_EN
    if (half_q) col = {1'b0, col[23:17], 1'b0, col[15:9], 1'b0, col[7:1]};
`endif
  end

  assign R        = col[23:16];
  assign G        = col[15:8];
  assign B        = col[7:0];
  assign HSync    = tim_q.hsync;
  assign VSync    = tim_q.vsync;
  assign HBlank   = tim_q.hblank;
  assign VBlank   = tim_q.vblank;
  assign video_de = tim_q.de;

endmodule

// File: tb/tb_pixie_line_doubler.sv
// Directed bench for pixie_line_doubler: steady replay table, vertical sync,
// buffer overflow, long line and asynchronous reset.
module tb_pixie_line_doubler;
  import pixie_video_pkg::*;

  localparam int LOGN = 16384;
  localparam int S_HS = 0, S_DE = 1, S_HB = 2, S_VS = 3, S_ERR = 4;
  localparam logic [23:0] FG_H1 =
`ifdef PIXIE_SCANLINES_EN
    24'h7F7F7F;
`else
    24'hFFFFFF;
`endif

  logic clk = 1'b0, reset = 1'b1, pix_ce = 1'b0;
  logic video_in = 1'b0, HSync_in = 1'b0, VSync_in = 1'b0, HBlank_in = 1'b1;
  logic VBlank_in = 1'b0, video_de_in = 1'b0;
  logic [7:0] R, G, B;
  logic HSync, VSync, HBlank, VBlank, video_de, line_err;

  pixie_line_doubler dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .video_in(video_in),
    .HSync_in(HSync_in), .VSync_in(VSync_in), .HBlank_in(HBlank_in),
    .VBlank_in(VBlank_in), .video_de_in(video_de_in),
    .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync), .HBlank(HBlank),
    .VBlank(VBlank), .video_de(video_de), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        lg_hs [0:LOGN-1];
  logic        lg_de [0:LOGN-1];
  logic        lg_hb [0:LOGN-1];
  logic        lg_vs [0:LOGN-1];
  logic        lg_vb [0:LOGN-1];
  logic        lg_err[0:LOGN-1];
  logic [23:0] lg_rgb[0:LOGN-1];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      lg_hs[cyc]  = HSync;
      lg_de[cyc]  = video_de;
      lg_hb[cyc]  = HBlank;
      lg_vs[cyc]  = VSync;
      lg_vb[cyc]  = VBlank;
      lg_err[cyc] = line_err;
      lg_rgb[cyc] = {R, G, B};
    end
  end

  int n_pass = 0, n_total = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  function automatic int cnt(input int sel, input int a, input int b);
    int n;
    n = 0;
    for (int t = a; t <= b; t++) begin
      case (sel)
        S_HS:    if (lg_hs[t]  === 1'b1) n++;
        S_DE:    if (lg_de[t]  === 1'b1) n++;
        S_HB:    if (lg_hb[t]  === 1'b1) n++;
        S_VS:    if (lg_vs[t]  === 1'b1) n++;
        default: if (lg_err[t] === 1'b1) n++;
      endcase
    end
    return n;
  endfunction

  int rc[0:31];
  int nl = 0;

  // One input line: each sample is a pix_ce=1 clk followed by a pix_ce=0 clk.
  task automatic send_line(input int len, input int hw, input int ds, input int dl,
                           input bit vs, input bit flip_hi);
    int idx;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) begin rc[nl] = cyc + 1; nl++; end
      idx         = i - ds;
      pix_ce      = 1'b1;
      HSync_in    = (i < hw);
      VSync_in    = vs;
      VBlank_in   = vs;
      video_de_in = (i >= ds) && (i < ds + dl);
      HBlank_in   = !video_de_in;
      video_in    = video_de_in ? (idx[0] ^ (flip_hi && idx >= 256)) : 1'b0;
      @(negedge clk);
      pix_ce = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pix_ce = 1'b0; HSync_in = 1'b0; VSync_in = 1'b0;
    VBlank_in = 1'b0; video_de_in = 1'b0; video_in = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    nl = 0;
  endtask

  typedef struct {
    int          off;
    logic        hs;
    logic        de;
    logic        hb;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[19];
  int   base;

  initial begin
    tbl[0]  = '{0,   1'b1, 1'b0, 1'b1, 24'h000000};
    tbl[1]  = '{11,  1'b1, 1'b0, 1'b1, 24'h000000};
    tbl[2]  = '{12,  1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[3]  = '{31,  1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[4]  = '{32,  1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[5]  = '{33,  1'b0, 1'b1, 1'b0, 24'hFFFFFF};
    tbl[6]  = '{94,  1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[7]  = '{95,  1'b0, 1'b1, 1'b0, 24'hFFFFFF};
    tbl[8]  = '{96,  1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[9]  = '{111, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[10] = '{112, 1'b1, 1'b0, 1'b1, 24'h000000};
    tbl[11] = '{144, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[12] = '{145, 1'b0, 1'b1, 1'b0, FG_H1};
    tbl[13] = '{207, 1'b0, 1'b1, 1'b0, FG_H1};
    tbl[14] = '{208, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[15] = '{223, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[16] = '{224, 1'b1, 1'b0, 1'b1, 24'h000000};
    tbl[17] = '{256, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[18] = '{257, 1'b0, 1'b1, 1'b0, 24'hFFFFFF};

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    chk("rst_hsync", HSync, 0);
    chk("rst_hblank", HBlank, 1);
    chk("rst_vblank", VBlank, 1);
    chk("rst_rgb", {R, G, B}, 0);
    do_reset();

    // Steady lines P=112 HW=12 DS=32 DL=64; lines 4..7 carry VSync
    for (int l = 0; l < 10; l++)
      send_line(112, 12, 32, 64, (l >= 4 && l < 8), 1'b0);
    send_line(30, 12, 32, 64, 1'b0, 1'b0);

    chk("lat_pre_hs", lg_hs[rc[1]], 0);
    chk("lat_pre_hb", lg_hb[rc[1]], 1);
    chk("lat_first_hs", lg_hs[rc[1] + 1], 1);
    base = rc[2] + 1;
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("vec%0d_hs", i), lg_hs[base + tbl[i].off], tbl[i].hs);
      chk($sformatf("vec%0d_de", i), lg_de[base + tbl[i].off], tbl[i].de);
      chk($sformatf("vec%0d_hb", i), lg_hb[base + tbl[i].off], tbl[i].hb);
      chk($sformatf("vec%0d_rgb", i), lg_rgb[base + tbl[i].off], tbl[i].rgb);
    end
    chk("pair_hs_count", cnt(S_HS, base, base + 223), 24);
    chk("pair_de_count", cnt(S_DE, base, base + 223), 128);
    chk("steady_no_err", cnt(S_ERR, rc[0], rc[9]), 0);
    chk("vs_before", lg_vs[rc[4]], 0);
    chk("vs_start", lg_vs[rc[4] + 1], 1);
    chk("vs_last", lg_vs[rc[8]], 1);
    chk("vs_after", lg_vs[rc[8] + 1], 0);
    chk("vs_count", cnt(S_VS, rc[4] - 5, rc[8] + 5), 896);
    chk("vb_start", lg_vb[rc[4] + 1], 1);
    chk("vb_after", lg_vb[rc[8] + 1], 0);

    // Async reset mid-line while de is active on an odd (FG) pixel
    #1;
    chk("pre_rst_de", video_de, 1);
    chk("pre_rst_rgb", {R, G, B}, 24'hFFFFFF);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_de", video_de, 0);
    chk("mid_rst_hb", HBlank, 1);
    chk("mid_rst_vb", VBlank, 1);
    chk("mid_rst_hs", HSync, 0);
    chk("mid_rst_rgb", {R, G, B}, 0);
    chk("mid_rst_err", line_err, 0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    do_reset();

    // Overflow: DL=300 > MAX_PIX; de pixels 256+ carry inverted data
    for (int l = 0; l < 4; l++)
      send_line(400, 12, 32, 300, 1'b0, 1'b1);
    base = rc[2] + 1;
    chk("ovf_err_pulse", cnt(S_ERR, rc[1] + 1, rc[2]), 1);
    chk("ovf_de_pre", lg_de[base + 31], 0);
    chk("ovf_de_first", lg_de[base + 32], 1);
    chk("ovf_pix0", lg_rgb[base + 32], 24'h000000);
    chk("ovf_pix1", lg_rgb[base + 33], 24'hFFFFFF);
    chk("ovf_pix255", lg_rgb[base + 287], 24'hFFFFFF);
    chk("ovf_de_end", lg_de[base + 288], 0);
    chk("ovf_de_count", cnt(S_DE, base, base + 399), 256);
    do_reset();

    // Long line: line 3 is P+10 samples; DS=4 so forced blanking is visible
    for (int l = 0; l < 6; l++)
      send_line((l == 3) ? 122 : 112, 12, 4, 64, 1'b0, 1'b0);
    chk("long_norm_de", lg_de[rc[3] + 1 + 4], 1);
    chk("long_last_hb", lg_hb[rc[3] + 224], 1);
    chk("long_force_de", cnt(S_DE, rc[3] + 225, rc[3] + 244), 0);
    chk("long_force_hb", cnt(S_HB, rc[3] + 225, rc[3] + 244), 20);
    chk("long_resume_hs", lg_hs[rc[4] + 1], 1);
    chk("long_resume_de_pre", lg_de[rc[4] + 4], 0);
    chk("long_resume_de", lg_de[rc[4] + 5], 1);
    chk("long_p_half_pre", lg_hs[rc[4] + 122], 0);
    chk("long_p_half", lg_hs[rc[4] + 123], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
